// File: rtl/spi_stream_shifter.sv
// ---------------------------------------------------------------------------
// spi_stream_shifter
//
// Full-duplex SPI-style shifter with a TX FIFO for SSD1306 command/data
// streaming. Words pushed by the sequencer are queued, then shifted out on
// serial_out while serial_in is assembled into rx_data. Consecutive queued
// words share one chip-select frame. Each word carries its own D/C level,
// which appears on dc_out for as long as that word is in flight.
//
// Parameters:
//   WIDTH      - bits per word
//   FIFO_DEPTH - TX FIFO entries (power of two, >= 2)
//   DIV_WIDTH  - width of cfg_div
//
// Ports:
//   clk_in        - system clock
//   reset         - synchronous, active-high reset
//   cfg_div       - SCLK half-period is cfg_div+1 clk_in cycles (latched per word)
//   cfg_cpol      - SCLK idle level (latched per burst)
//   cfg_lsb_first - 1: LSB first, 0: MSB first (latched per burst)
//   wr_valid      - push request
//   wr_data       - word to transmit
//   wr_dc         - D/C level for this word
//   wr_ready      - FIFO can accept a push this cycle
//   fifo_level    - words currently queued
//   busy          - shifter active or FIFO non-empty
//   rx_valid      - one-cycle pulse, rx_data valid
//   rx_data       - word received on serial_in, same bit order as sent
//   sclk          - serial clock (registered)
//   cs_n          - chip select, active low (registered)
//   dc_out        - D/C of the word in flight (registered)
//   serial_out    - MOSI (registered)
//   serial_in     - MISO
// ---------------------------------------------------------------------------
module spi_stream_shifter #(
    parameter int WIDTH      = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int DIV_WIDTH  = 8
) (
    input  logic                              clk_in,
    input  logic                              reset,
    input  logic [DIV_WIDTH-1:0]              cfg_div,
    input  logic                              cfg_cpol,
    input  logic                              cfg_lsb_first,
    input  logic                              wr_valid,
    input  logic [WIDTH-1:0]                  wr_data,
    input  logic                              wr_dc,
    output logic                              wr_ready,
    output logic [$clog2(FIFO_DEPTH+1)-1:0]   fifo_level,
    output logic                              busy,
    output logic                              rx_valid,
    output logic [WIDTH-1:0]                  rx_data,
    output logic                              sclk,
    output logic                              cs_n,
    output logic                              dc_out,
    output logic                              serial_out,
    input  logic                              serial_in
);

    localparam int LVL_W  = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int EDGE_W = $clog2(2 * WIDTH);
    localparam logic [EDGE_W-1:0] LAST_EDGE = EDGE_W'(2 * WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        SHIFT,
        HOLD
    } state_t;

    state_t state;
    state_t state_next;

    // ------------------------------------------------------------------
    // TX FIFO: entries hold {dc, data}
    // ------------------------------------------------------------------
    logic [WIDTH:0]     mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [LVL_W-1:0]   level;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;
    logic [WIDTH:0]     head;
    logic [WIDTH-1:0]   head_data;
    logic               head_dc;

    assign full       = (level == LVL_W'(FIFO_DEPTH));
    assign empty      = (level == '0);
    assign wr_ready   = !full && !reset;
    assign push       = wr_valid && wr_ready;
    assign head       = mem[rd_ptr];
    assign head_data  = head[WIDTH-1:0];
    assign head_dc    = head[WIDTH];
    assign fifo_level = level;

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem[wr_ptr] <= {wr_dc, wr_data};
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Shifter datapath registers
    // ------------------------------------------------------------------
    logic [WIDTH-1:0]     tx_shift;
    logic [WIDTH-1:0]     rx_shift;
    logic [WIDTH-1:0]     tx_next;
    logic [WIDTH-1:0]     rx_next;
    logic [DIV_WIDTH-1:0] div_q;
    logic [DIV_WIDTH-1:0] div_cnt;
    logic [EDGE_W-1:0]    edge_cnt;
    logic                 cpol_q;
    logic                 lsb_q;
    logic                 tick;

    // FSM strobes
    logic                 load;
    logic                 sclk_edge;
    logic                 lead;
    logic                 last;

    assign tick = (div_cnt == div_q);
    assign busy = (state != IDLE) || !empty;

    always_comb begin
        tx_next = lsb_q ? (tx_shift >> 1) : (tx_shift << 1);
        rx_next = lsb_q ? {serial_in, rx_shift[WIDTH-1:1]}
                        : {rx_shift[WIDTH-2:0], serial_in};
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // SETUP is a single load cycle; the half-period before the first leading
    // edge is then counted in SHIFT with edge_cnt=0. This makes the first word
    // of a burst and every back-to-back reload share the same timing path.
    always_comb begin
        state_next = state;
        load       = 1'b0;
        sclk_edge  = 1'b0;
        lead       = 1'b0;
        last       = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    state_next = SETUP;
                end
            end
            SETUP: begin
                load       = 1'b1;
                state_next = SHIFT;
            end
            SHIFT: begin
                if (tick) begin
                    sclk_edge = 1'b1;
                    lead      = !edge_cnt[0];
                    if (edge_cnt == LAST_EDGE) begin
                        last = 1'b1;
                        // Registered level: a push landing on this edge is not seen.
                        if (!empty) begin
                            load = 1'b1;
                        end else begin
                            state_next = HOLD;
                        end
                    end
                end
            end
            HOLD: begin
                if (tick) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign pop = load;

    // ------------------------------------------------------------------
    // Datapath and registered pin outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk_in) begin
        if (reset) begin
            sclk       <= 1'b0;
            cs_n       <= 1'b1;
            dc_out     <= 1'b0;
            serial_out <= 1'b0;
            rx_valid   <= 1'b0;
            rx_data    <= '0;
            tx_shift   <= '0;
            rx_shift   <= '0;
            div_q      <= '0;
            div_cnt    <= '0;
            edge_cnt   <= '0;
            cpol_q     <= 1'b0;
            lsb_q      <= 1'b0;
        end else begin
            rx_valid <= 1'b0;
            case (state)
                IDLE: begin
                    sclk    <= cfg_cpol;
                    cs_n    <= 1'b1;
                    div_cnt <= '0;
                    if (!empty) begin
                        cpol_q <= cfg_cpol;
                        lsb_q  <= cfg_lsb_first;
                    end
                end
                SETUP: begin
                    sclk <= cpol_q;
                    cs_n <= 1'b0;
                end
                SHIFT: begin
                    div_cnt <= tick ? '0 : div_cnt + DIV_WIDTH'(1);
                    if (sclk_edge) begin
                        sclk     <= ~sclk;
                        edge_cnt <= edge_cnt + EDGE_W'(1);
                        if (lead) begin
                            rx_shift <= rx_next;
                        end else if (!last) begin
                            tx_shift   <= tx_next;
                            serial_out <= lsb_q ? tx_next[0] : tx_next[WIDTH-1];
                        end
                    end
                    if (last) begin
                        edge_cnt <= '0;
                        rx_valid <= 1'b1;
                        rx_data  <= rx_shift;
                    end
                end
                HOLD: begin
                    div_cnt <= tick ? '0 : div_cnt + DIV_WIDTH'(1);
                    if (tick) begin
                        cs_n <= 1'b1;
                    end
                end
                default: begin
                    cs_n <= 1'b1;
                end
            endcase

            // Word load (first of a burst or gapless reload) overrides counters.
            if (load) begin
                tx_shift   <= head_data;
                serial_out <= lsb_q ? head_data[0] : head_data[WIDTH-1];
                dc_out     <= head_dc;
                div_q      <= cfg_div;
                div_cnt    <= '0;
                edge_cnt   <= '0;
            end
        end
    end

endmodule

// File: tb/tb_spi_stream_shifter.sv
// ---------------------------------------------------------------------------
// tb_spi_stream_shifter
//
// Self-checking bench for spi_stream_shifter. A monitor reconstructs each
// word from the pins (MOSI at every SCLK leading edge, half-period lengths,
// frame length) and compares against a queue of expected words; directed
// scenarios plus randomized bursts drive the stimulus.
// ---------------------------------------------------------------------------
module tb_spi_stream_shifter;

    localparam int W  = 8;
    localparam int D  = 4;
    localparam int DW = 8;

    logic              clk_in = 1'b0;
    logic              reset;
    logic [DW-1:0]     cfg_div;
    logic              cfg_cpol;
    logic              cfg_lsb_first;
    logic              wr_valid;
    logic [W-1:0]      wr_data;
    logic              wr_dc;
    logic              wr_ready;
    logic [2:0]        fifo_level;
    logic              busy;
    logic              rx_valid;
    logic [W-1:0]      rx_data;
    logic              sclk;
    logic              cs_n;
    logic              dc_out;
    logic              serial_out;
    logic              serial_in;
    logic              inv_mode;

    // Loopback, optionally inverted so rx must equal ~tx.
    assign serial_in = serial_out ^ inv_mode;

    always #5 clk_in = ~clk_in;

    spi_stream_shifter #(
        .WIDTH      (W),
        .FIFO_DEPTH (D),
        .DIV_WIDTH  (DW)
    ) dut (
        .clk_in        (clk_in),
        .reset         (reset),
        .cfg_div       (cfg_div),
        .cfg_cpol      (cfg_cpol),
        .cfg_lsb_first (cfg_lsb_first),
        .wr_valid      (wr_valid),
        .wr_data       (wr_data),
        .wr_dc         (wr_dc),
        .wr_ready      (wr_ready),
        .fifo_level    (fifo_level),
        .busy          (busy),
        .rx_valid      (rx_valid),
        .rx_data       (rx_data),
        .sclk          (sclk),
        .cs_n          (cs_n),
        .dc_out        (dc_out),
        .serial_out    (serial_out),
        .serial_in     (serial_in)
    );

    typedef struct packed {
        logic [W-1:0] data;
        logic         dc;
    } word_t;

    word_t exp_q[$];

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, want, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Pin monitor
    // ------------------------------------------------------------------
    logic          m_prev_cs = 1'b1;
    logic          m_prev_sclk = 1'b0;
    logic          m_cpol = 1'b0;
    logic [W-1:0]  m_bits = '0;
    int            m_since = 0;
    int            m_low = 0;
    int            m_toggles = 0;
    int            m_words = 0;
    int            m_nbits = 0;
    int            m_bursts = 0;
    int            hp;
    word_t         mw;

    always @(posedge clk_in) begin
        #1;
        if (reset) begin
            m_prev_cs   = 1'b1;
            m_prev_sclk = sclk;
            m_nbits     = 0;
            m_bits      = '0;
        end else begin
            hp = int'(cfg_div) + 1;
            if (m_prev_cs && !cs_n) begin
                m_cpol    = sclk;
                m_since   = 0;
                m_low     = 1;
                m_toggles = 0;
                m_words   = 0;
                m_nbits   = 0;
                m_bursts++;
            end else if (!cs_n) begin
                m_since++;
                m_low++;
                if (sclk != m_prev_sclk) begin
                    check("half_period", m_since, hp);
                    m_since = 0;
                    m_toggles++;
                    if (sclk != m_cpol) begin
                        m_nbits++;
                        m_bits = cfg_lsb_first ? {serial_out, m_bits[W-1:1]}
                                               : {m_bits[W-2:0], serial_out};
                        if (exp_q.size() == 0) check("stray_bit", 1, 0);
                        else                   check("dc_out", dc_out, exp_q[0].dc);
                    end
                end
            end else if (!m_prev_cs) begin
                m_since++;
                check("hold_len", m_since, hp);
                check("cs_low_len", m_low, m_words * 2 * W * hp + hp);
                check("sclk_edges", m_toggles, m_words * 2 * W);
            end
            if (rx_valid) begin
                if (exp_q.size() == 0) begin
                    check("stray_rx", 1, 0);
                end else begin
                    mw = exp_q.pop_front();
                    check("rx_data", rx_data, mw.data ^ {W{inv_mode}});
                    check("mosi_word", m_bits, mw.data);
                    check("bits_per_word", m_nbits, W);
                end
                m_words++;
                m_nbits = 0;
            end
            m_prev_cs   = cs_n;
            m_prev_sclk = sclk;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic push_word(input logic [W-1:0] d, input logic dc, input bit accept);
        word_t e;
        @(negedge clk_in);
        wr_valid = 1'b1;
        wr_data  = d;
        wr_dc    = dc;
        if (accept) begin
            e.data = d;
            e.dc   = dc;
            exp_q.push_back(e);
        end
    endtask

    task automatic end_push;
        @(negedge clk_in);
        wr_valid = 1'b0;
    endtask

    // Single push into an idle, empty block; checks two-edge start latency.
    task automatic push_and_check_start(input logic [W-1:0] d, input logic dc);
        logic first;
        push_word(d, dc, 1'b1);
        end_push();
        @(posedge clk_in); #1;
        check("cs_n_before_start", cs_n, 1);
        @(posedge clk_in); #1;
        first = cfg_lsb_first ? d[0] : d[W-1];
        check("cs_n_start", cs_n, 0);
        check("first_bit", serial_out, first);
        check("dc_start", dc_out, dc);
        check("sclk_start", sclk, cfg_cpol);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy || !cs_n) && n < budget) begin
            @(negedge clk_in);
            n++;
        end
        repeat (2) @(negedge clk_in);
        check("idle_reached", busy || !cs_n, 0);
        check("queue_drained", exp_q.size(), 0);
        check("level_idle", fifo_level, 0);
        check("ready_idle", wr_ready, 1);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    int b0;
    int n;
    int rx_cnt;

    initial begin
        reset         = 1'b1;
        cfg_div       = '0;
        cfg_cpol      = 1'b0;
        cfg_lsb_first = 1'b0;
        wr_valid      = 1'b0;
        wr_data       = '0;
        wr_dc         = 1'b0;
        inv_mode      = 1'b0;

        // Reset values
        repeat (3) @(negedge clk_in);
        check("rst_cs_n", cs_n, 1);
        check("rst_sclk", sclk, 0);
        check("rst_serial_out", serial_out, 0);
        check("rst_dc_out", dc_out, 0);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_data", rx_data, 0);
        check("rst_level", fifo_level, 0);
        check("rst_busy", busy, 0);
        check("rst_wr_ready", wr_ready, 0);
        reset = 1'b0;
        @(negedge clk_in);
        check("ready_after_reset", wr_ready, 1);

        // 0xA5, MSB first, div 0, cpol 0
        b0 = m_bursts;
        push_and_check_start(8'hA5, 1'b1);
        wait_idle(200);
        check("a5_bursts", m_bursts - b0, 1);

        // LSB first 0x01
        @(negedge clk_in);
        cfg_lsb_first = 1'b1;
        push_and_check_start(8'h01, 1'b0);
        wait_idle(200);

        // Three words back to back: one frame
        @(negedge clk_in);
        cfg_lsb_first = 1'b0;
        b0 = m_bursts;
        push_word(8'h11, 1'b0, 1'b1);
        push_word(8'h22, 1'b1, 1'b1);
        push_word(8'h33, 1'b1, 1'b1);
        end_push();
        wait_idle(500);
        check("b2b_bursts", m_bursts - b0, 1);

        // Overflow while shifting a long word
        @(negedge clk_in);
        cfg_div = DW'(7);
        push_and_check_start(8'h10, 1'b0);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_in);
            check("ovf_ready", wr_ready, (i < D) ? 1 : 0);
            check("ovf_level", fifo_level, (i < D) ? i : D);
            wr_valid = 1'b1;
            wr_data  = W'(8'hB0 + i);
            wr_dc    = i[0];
            if (i < D) begin
                mw.data = wr_data;
                mw.dc   = wr_dc;
                exp_q.push_back(mw);
            end
        end
        end_push();
        check("ovf_level_full", fifo_level, D);
        check("ovf_ready_full", wr_ready, 0);
        wait_idle(2000);

        // cpol 1, div 2
        @(negedge clk_in);
        cfg_cpol = 1'b1;
        cfg_div  = DW'(2);
        repeat (2) @(negedge clk_in);
        check("idle_sclk_high", sclk, 1);
        push_and_check_start(8'h3C, 1'b1);
        wait_idle(300);

        // Reset mid-word with two words queued
        @(negedge clk_in);
        cfg_cpol = 1'b0;
        cfg_div  = DW'(1);
        repeat (2) @(negedge clk_in);
        push_word(8'hC3, 1'b0, 1'b1);
        push_word(8'h11, 1'b1, 1'b1);
        push_word(8'h22, 1'b0, 1'b1);
        end_push();
        n = 0;
        while (m_nbits < 4 && n < 200) begin
            @(negedge clk_in);
            n++;
        end
        check("reach_bit4", m_nbits >= 4, 1);
        check("level_before_reset", fifo_level, 2);
        reset = 1'b1;
        exp_q.delete();
        @(posedge clk_in); #1;
        check("abort_cs_n", cs_n, 1);
        check("abort_sclk", sclk, 0);
        check("abort_level", fifo_level, 0);
        check("abort_rx_valid", rx_valid, 0);
        check("abort_busy", busy, 0);
        @(negedge clk_in);
        reset  = 1'b0;
        rx_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_in);
            if (rx_valid) rx_cnt++;
        end
        check("rx_after_reset", rx_cnt, 0);
        check("cs_after_reset", cs_n, 1);
        push_and_check_start(8'h5A, 1'b1);
        wait_idle(300);

        // Randomized bursts
        for (int it = 0; it < 24; it++) begin
            @(negedge clk_in);
            cfg_div       = DW'($urandom_range(0, 3));
            cfg_cpol      = 1'($urandom_range(0, 1));
            cfg_lsb_first = 1'($urandom_range(0, 1));
            inv_mode      = 1'($urandom_range(0, 1));
            repeat (2) @(negedge clk_in);
            check("rand_idle_sclk", sclk, cfg_cpol);
            b0 = m_bursts;
            n  = int'($urandom_range(1, D));
            for (int k = 0; k < n; k++) begin
                push_word(W'($urandom), 1'($urandom), 1'b1);
            end
            end_push();
            wait_idle(2000);
            check("rand_bursts", m_bursts - b0, 1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
